// File: rtl/blake2_pkg.sv
// blake2_pkg: shared constants, state encoding and final-word keep mask for the digest serializer.
// Rev 1.0
`default_nettype none

package blake2_pkg;

   localparam int BUS_WIDTH    = 64;
   localparam int DIGEST_WIDTH = 512;
   localparam int WORDS        = DIGEST_WIDTH / BUS_WIDTH;

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t SEND = 1'b1;

   // len is already clamped to 1..64; a multiple of 8 fills the final word.
   function automatic logic [7:0] keep_mask(input logic [6:0] len);
      logic [2:0] rem;
      rem = len[2:0];
      return (rem == 3'd0) ? 8'hFF : ((8'h01 << rem) - 8'h01);
   endfunction

endpackage

`default_nettype wire

// File: rtl/digest_word_mux.sv
// digest_word_mux: selects one bus word from the digest holding register, zeroes bytes outside keep.
// Rev 1.0 -- option: ENDIAN_SWAP_EN byte-reverses dout and bit-reverses keep.
`default_nettype none

module digest_word_mux
   import blake2_pkg::*;
(
   input  logic [DIGEST_WIDTH-1:0] hold_i,
   input  logic [2:0]              idx_i,
   input  logic [7:0]              keep_i,
   output logic [BUS_WIDTH-1:0]    dout_o,
   output logic [7:0]              keep_o
);

   logic [BUS_WIDTH-1:0] w_word;
   logic [BUS_WIDTH-1:0] w_masked;

   assign w_word = hold_i[{idx_i, 6'b000000} +: BUS_WIDTH];

   always_comb begin
      w_masked = '0;
      dout_o   = '0;
      keep_o   = '0;
      for (int b = 0; b < 8; b++) begin
         w_masked[8*b +: 8] = keep_i[b] ? w_word[8*b +: 8] : 8'h00;
      end
`ifdef ENDIAN_SWAP_EN
      for (int b = 0; b < 8; b++) begin
         dout_o[8*(7-b) +: 8] = w_masked[8*b +: 8];
         keep_o[7-b]          = keep_i[b];
      end
`else
      dout_o = w_masked;
      keep_o = keep_i;
`endif
   end

endmodule

`default_nettype wire

// File: rtl/digest_serializer.sv
// digest_serializer: captures a 512-bit Blake2 digest and streams it as 64-bit words with last/keep.
// Rev 1.0 -- option: ENDIAN_SWAP_EN (byte-reversed output words).
`default_nettype none

module digest_serializer
   import blake2_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    digest_valid,
   input  logic [DIGEST_WIDTH-1:0] digest,
   input  logic [6:0]              digest_len,
   output logic [BUS_WIDTH-1:0]    dout,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic                    last_out,
   output logic [7:0]              keep,
   output logic                    busy,
   output logic                    overrun
);

   state_t                  state_q, state_d;
   logic [2:0]              idx_q, idx_d;
   logic [6:0]              len_q, len_d;
   logic [3:0]              nw_q, nw_d;
   logic [DIGEST_WIDTH-1:0] hold_q;
   logic                    dv_q;
   logic                    overrun_q;

   logic       w_rise;
   logic       w_send;
   logic       w_last;
   logic       w_xfer;
   logic       w_capture;
   logic [6:0] w_len_clamp;
   logic [6:0] w_len_round;
   logic [7:0] w_keep_lsb;

   assign w_rise      = digest_valid & ~dv_q;
   assign w_send      = (state_q == SEND);
   assign w_last      = w_send && ({1'b0, idx_q} == (nw_q - 4'd1));
   assign w_xfer      = w_send && ready_in;
   assign w_capture   = w_rise && !w_send;
   assign w_len_clamp = ((digest_len == 7'd0) || (digest_len > 7'd64)) ? 7'd64 : digest_len;
   assign w_len_round = w_len_clamp + 7'd7;
   assign w_keep_lsb  = !w_send ? 8'h00 : (w_last ? keep_mask(len_q) : 8'hFF);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      nw_d    = nw_q;
      if (w_capture) begin
         state_d = SEND;
         idx_d   = 3'd0;
         len_d   = w_len_clamp;
         nw_d    = w_len_round[6:3];
      end else if (w_xfer) begin
         if (w_last) begin
            state_d = IDLE;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   // dv_q resets high so a level already present at reset release is not a new digest.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         len_q     <= 7'd0;
         nw_q      <= 4'd0;
         dv_q      <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         nw_q      <= nw_d;
         dv_q      <= digest_valid;
         overrun_q <= w_rise && w_send;
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture && reset_n) begin
         hold_q <= digest;
      end
   end

   digest_word_mux u_mux (
      .hold_i (hold_q),
      .idx_i  (idx_q),
      .keep_i (w_keep_lsb),
      .dout_o (dout),
      .keep_o (keep)
   );

   assign valid_out = w_send;
   assign last_out  = w_last;
   assign busy      = w_send;
   assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer: directed self-checking bench for digest_serializer.
`default_nettype none

module tb_digest_serializer;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         digest_valid;
   logic [511:0] digest;
   logic [6:0]   digest_len;
   logic [63:0]  dout;
   logic         valid_out;
   logic         ready_in;
   logic         last_out;
   logic [7:0]   keep;
   logic         busy;
   logic         overrun;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0]  last_keep_seen;
   logic [63:0] first_word_seen;

   always #5 clk = ~clk;

   digest_serializer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .digest_valid (digest_valid),
      .digest       (digest),
      .digest_len   (digest_len),
      .dout         (dout),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .last_out     (last_out),
      .keep         (keep),
      .busy         (busy),
      .overrun      (overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] exp_word(input logic [511:0] d, input int i, input int len);
      logic [63:0] w;
      logic [7:0]  by;
      w = '0;
      for (int b = 0; b < 8; b++) begin
         by = ((8*i + b) < len) ? d[8*(8*i+b) +: 8] : 8'h00;
`ifdef ENDIAN_SWAP_EN
         w[8*(7-b) +: 8] = by;
`else
         w[8*b +: 8] = by;
`endif
      end
      return w;
   endfunction

   function automatic logic [7:0] exp_keep(input int i, input int len);
      logic [7:0] k;
      k = '0;
      for (int b = 0; b < 8; b++) begin
`ifdef ENDIAN_SWAP_EN
         k[7-b] = ((8*i + b) < len);
`else
         k[b] = ((8*i + b) < len);
`endif
      end
      return k;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, {63'd0, valid_out}, 64'd0);
      chk({tag, "_last"},  {63'd0, last_out},  64'd0);
      chk({tag, "_keep"},  {56'd0, keep},      64'd0);
      chk({tag, "_dout"},  dout,               64'd0);
      chk({tag, "_busy"},  {63'd0, busy},      64'd0);
   endtask

   // Captures d/len_in, then drains the stream; optional toggled ready, a rise at word
   // ovr_at (expects overrun), or a reset at word rst_at (expects all outputs zero).
   task automatic run_stream(input string tag, input logic [511:0] d, input logic [6:0] len_in,
                             input bit toggle, input int ovr_at, input int rst_at);
      int  L, nw, i, cyc;
      bit  ovr_done, ovr_pend;
      L  = (len_in == 7'd0 || len_in > 7'd64) ? 64 : int'(len_in);
      nw = (L + 7) / 8;
      digest       = d;
      digest_len   = len_in;
      digest_valid = 1'b1;
      ready_in     = 1'b1;
      tick();
      digest_valid = 1'b0;
      digest       = ~d;
      digest_len   = 7'd3;
      i = 0; cyc = 0; ovr_done = 0; ovr_pend = 0;
      while (i < nw && cyc < 200) begin
         ready_in = toggle ? (cyc % 2 == 0) : 1'b1;
         chk({tag, "_valid"}, {63'd0, valid_out}, 64'd1);
         chk({tag, "_dout"},  dout, exp_word(d, i, L));
         chk({tag, "_keep"},  {56'd0, keep}, {56'd0, exp_keep(i, L)});
         chk({tag, "_last"},  {63'd0, last_out}, {63'd0, (i == nw - 1)});
         if (i == 0) first_word_seen = dout;
         last_keep_seen = keep;
         if (i == rst_at) begin
            reset_n = 1'b0;
            tick();
            check_idle({tag, "_rst"});
            chk({tag, "_rst_ovr"}, {63'd0, overrun}, 64'd0);
            reset_n = 1'b1;
            tick();
            return;
         end
         if (i == ovr_at && !ovr_done) begin
            digest_valid = 1'b1;
            ovr_done     = 1;
            ovr_pend     = 1;
         end
         tick();
         chk({tag, "_ovr"}, {63'd0, overrun}, {63'd0, ovr_pend});
         ovr_pend = 0;
         if (ready_in) i++;
         cyc++;
      end
      chk({tag, "_timeout"}, {63'd0, (cyc >= 200)}, 64'd0);
      check_idle({tag, "_end"});
      tick();
      chk({tag, "_nocap"}, {63'd0, busy}, 64'd0);
      digest_valid = 1'b0;
      tick();
   endtask

   logic [511:0] d_inc, d_a, d_b;

   initial begin
      for (int k = 0; k < 64; k++) begin
         d_inc[8*k +: 8] = 8'(k);
         d_a[8*k +: 8]   = 8'(8'hA5 ^ (k * 7));
         d_b[8*k +: 8]   = 8'(8'h3C + k * 13);
      end
      reset_n      = 1'b0;
      digest_valid = 1'b1;
      digest       = d_inc;
      digest_len   = 7'd64;
      ready_in     = 1'b0;
      last_keep_seen  = '0;
      first_word_seen = '0;
      tick(); tick();
      check_idle("rst");
      chk("rst_ovr", {63'd0, overrun}, 64'd0);

      // Level held high across reset release is not a new digest.
      reset_n = 1'b1;
      tick(); tick(); tick();
      check_idle("rel");
      digest_valid = 1'b0;
      tick();

      run_stream("full64", d_inc, 7'd64, 1'b0, -1, -1);
`ifdef ENDIAN_SWAP_EN
      chk("full64_w0_hand", first_word_seen, 64'h0001020304050607);
`else
      chk("full64_w0_hand", first_word_seen, 64'h0706050403020100);
`endif
      chk("full64_lastkeep_hand", {56'd0, last_keep_seen}, 64'hFF);

      run_stream("len20", d_inc, 7'd20, 1'b1, -1, -1);
`ifdef ENDIAN_SWAP_EN
      chk("len20_w0_hand", first_word_seen, 64'h0001020304050607);
      chk("len20_lastkeep_hand", {56'd0, last_keep_seen}, 64'hF0);
`else
      chk("len20_lastkeep_hand", {56'd0, last_keep_seen}, 64'h0F);
`endif

      run_stream("len1", d_a, 7'd1, 1'b0, -1, -1);
`ifdef ENDIAN_SWAP_EN
      chk("len1_keep_hand", {56'd0, last_keep_seen}, 64'h80);
`else
      chk("len1_keep_hand", {56'd0, last_keep_seen}, 64'h01);
`endif

      run_stream("ovr_mid", d_a, 7'd0, 1'b0, 3, -1);
      run_stream("fresh", d_b, 7'd100, 1'b0, -1, -1);
      run_stream("ovr_last", d_b, 7'd13, 1'b0, 1, -1);
      run_stream("rst_mid", d_a, 7'd64, 1'b0, -1, 4);
      run_stream("after_rst", d_b, 7'd40, 1'b1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
